// File: rtl/ascon_perm_pkg.sv
// ascon_perm_pkg: shared ASCON types, round constants, S-box table and
// rotation amounts used by the permutation core and its round function.
package ascon_perm_pkg;

    typedef logic [7:0]   u8_t;
    typedef logic [63:0]  u64_t;
    typedef logic [319:0] u320_t;
    typedef logic [3:0]   rnd_t;

    // x0 occupies the most significant word, so a u320_t casts directly.
    typedef struct packed {
        u64_t x0;
        u64_t x1;
        u64_t x2;
        u64_t x3;
        u64_t x4;
    } state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam int unsigned MAX_ROUNDS = 12;

    // Linear-layer rotation amounts per word x0..x4.
    localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

    localparam u8_t RndConst [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // Indexed by {x0,x1,x2,x3,x4} bit column, x0 as MSB.
    localparam logic [4:0] Sbox [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic u64_t ror64(input u64_t v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Out-of-range indices (counter parked at 12 or beyond) yield zero so the
    // idle round chain never reads past the table.
    function automatic u8_t rnd_const(input logic [4:0] idx);
        u8_t c;
        c = '0;
        if (idx < 5'(MAX_ROUNDS)) begin
            c = RndConst[idx[3:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON round.
//   i_state : state before the round
//   i_const : round constant XORed into x2[7:0]
//   o_state : state after constant addition, S-box layer and linear layer
module ascon_round
    import ascon_perm_pkg::*;
(
    input  state_t i_state,
    input  u8_t    i_const,
    output state_t o_state
);

    state_t     w_add;
    state_t     w_sub;
    logic [4:0] w_sv;

    always_comb begin
        w_add          = i_state;
        w_add.x2[7:0]  = i_state.x2[7:0] ^ i_const;
    end

    // Bit-sliced substitution: each bit column is one 5-bit S-box lookup.
    always_comb begin
        w_sub = '0;
        w_sv  = '0;
        for (int unsigned j = 0; j < 64; j++) begin
            w_sv = Sbox[{w_add.x0[j], w_add.x1[j], w_add.x2[j], w_add.x3[j], w_add.x4[j]}];
            w_sub.x0[j] = w_sv[4];
            w_sub.x1[j] = w_sv[3];
            w_sub.x2[j] = w_sv[2];
            w_sub.x3[j] = w_sv[1];
            w_sub.x4[j] = w_sv[0];
        end
    end

    always_comb begin
        o_state.x0 = w_sub.x0 ^ ror64(w_sub.x0, ROT_A[0]) ^ ror64(w_sub.x0, ROT_B[0]);
        o_state.x1 = w_sub.x1 ^ ror64(w_sub.x1, ROT_A[1]) ^ ror64(w_sub.x1, ROT_B[1]);
        o_state.x2 = w_sub.x2 ^ ror64(w_sub.x2, ROT_A[2]) ^ ror64(w_sub.x2, ROT_B[2]);
        o_state.x3 = w_sub.x3 ^ ror64(w_sub.x3, ROT_A[3]) ^ ror64(w_sub.x3, ROT_B[3]);
        o_state.x4 = w_sub.x4 ^ ror64(w_sub.x4, ROT_A[4]) ^ ror64(w_sub.x4, ROT_B[4]);
    end

endmodule

// File: rtl/ascon_perm.sv
// ascon_perm: iterative ASCON permutation, UNROLL (1 or 2) rounds per clock,
// 1..12 rounds selected per request.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : request handshake (ready only while idle)
//   in_state_i, in_rounds_i  : 320-bit state (x0 in MSBs) and round count
//   out_valid_o / out_ready_i: result handshake, result held until taken
//   out_state_o              : permuted state (the state register itself)
//   out_err_o                : request was illegal, state returned unchanged
module ascon_perm
    import ascon_perm_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  u320_t in_state_i,
    input  rnd_t  in_rounds_i,
    output logic  out_valid_o,
    input  logic  out_ready_i,
    output u320_t out_state_o,
    output logic  out_err_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_perm: UNROLL must be 1 or 2");
    end

    fsm_t       r_fsm;
    fsm_t       w_fsm_nxt;
    state_t     r_state;
    logic [4:0] r_cnt;
    logic       r_err;

    logic       w_illegal;
    logic [4:0] w_cnt_next;
    logic       w_last;
    state_t     w_chain [UNROLL+1];

    assign w_chain[0] = r_state;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [4:0] w_idx;
        u8_t        w_const;
        assign w_idx   = r_cnt + 5'(g);
        assign w_const = rnd_const(w_idx);
        ascon_round u_round (
            .i_state (w_chain[g]),
            .i_const (w_const),
            .o_state (w_chain[g+1])
        );
    end

    assign w_illegal  = (in_rounds_i == '0)
                     || (in_rounds_i > rnd_t'(MAX_ROUNDS))
                     || ((UNROLL == 2) && in_rounds_i[0]);
    assign w_cnt_next = r_cnt + 5'(UNROLL);
    assign w_last     = (w_cnt_next == 5'(MAX_ROUNDS));

    // An illegal request spends one RUN cycle with the state held so that its
    // result appears one cycle after accept, like the shortest legal job.
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE: if (in_valid_i)       w_fsm_nxt = ST_RUN;
            ST_RUN:  if (r_err || w_last)  w_fsm_nxt = ST_DONE;
            ST_DONE: if (out_ready_i)      w_fsm_nxt = ST_IDLE;
            default:                       w_fsm_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        r_state <= state_t'(in_state_i);
                        r_cnt   <= 5'(MAX_ROUNDS) - {1'b0, in_rounds_i};
                        r_err   <= w_illegal;
                    end
                end
                ST_RUN: begin
                    if (!r_err) begin
                        r_state <= w_chain[UNROLL];
                        r_cnt   <= w_cnt_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (r_fsm == ST_IDLE);
    assign out_valid_o = (r_fsm == ST_DONE);
    assign out_state_o = r_state;
    assign out_err_o   = r_err;

endmodule

// File: tb/tb_ascon_perm.sv
// tb_ascon_perm: self-checking bench for ascon_perm with UNROLL=1 (index 0)
// and UNROLL=2 (index 1) instances, compared against a word-level model of
// the ASCON permutation written from the algorithm description.
module tb_ascon_perm;

    logic         clk;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [319:0] in_state;
    logic [3:0]   in_rounds;
    logic         out_valid [2];
    logic         out_ready [2];
    logic [319:0] out_state [2];
    logic         out_err   [2];

    int n_checks = 0;
    int n_fail   = 0;

    ascon_perm #(.UNROLL(1)) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .in_state_i  (in_state),
        .in_rounds_i (in_rounds),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready[0]),
        .out_state_o (out_state[0]),
        .out_err_o   (out_err[0])
    );

    ascon_perm #(.UNROLL(2)) u_dut2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .in_state_i  (in_state),
        .in_rounds_i (in_rounds),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready[1]),
        .out_state_o (out_state[1]),
        .out_err_o   (out_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Rounds 12-R .. 11 of p^12, constants generated as ((15-i)<<4)|i and the
    // S-box evaluated with its boolean form rather than a lookup table.
    function automatic logic [319:0] model_perm(input logic [319:0] s, input int rounds);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int ra [5];
        int rb [5];
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int i = 12 - rounds; i < 12; i++) begin
            x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
            x[0] = x[0] ^ x[4];
            x[4] = x[4] ^ x[3];
            x[2] = x[2] ^ x[1];
            for (int k = 0; k < 5; k++) t[k] = x[k] ^ (~x[(k+1)%5] & x[(k+2)%5]);
            t[1] = t[1] ^ t[0];
            t[0] = t[0] ^ t[4];
            t[3] = t[3] ^ t[2];
            t[2] = ~t[2];
            for (int k = 0; k < 5; k++) x[k] = t[k] ^ rot(t[k], ra[k]) ^ rot(t[k], rb[k]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- drive helpers (no comparisons) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int u, input logic [319:0] s, input int r);
        in_state    = s;
        in_rounds   = 4'(r);
        in_valid[u] = 1'b1;
        tick();
        in_valid[u] = 1'b0;
    endtask

    task automatic wait_valid(input int u, output int lat);
        lat = 0;
        while (out_valid[u] !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input int u);
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            out_ready[u] = 1'b0;
        end
        in_state  = '0;
        in_rounds = '0;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({in_ready[u], out_valid[u], out_err[u]} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got rdy/vld/err=%b%b%b expected 100", u, in_ready[u], out_valid[u], out_err[u]);
            end
            n_checks++;
            if (out_state[u] !== '0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %h expected 0", u, out_state[u]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_r12();
        int lat;
        logic [319:0] exp_s;
        exp_s = model_perm('0, 12);
        n_checks++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b expected 1", in_ready[0]);
        end
        start_job(0, '0, 12);
        wait_valid(0, lat);
        n_checks++;
        if (lat !== 12) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d expected 12", lat);
        end
        n_checks++;
        if (out_state[0] !== exp_s) begin
            n_fail++;
            $display("FAIL zero_state: got %h expected %h", out_state[0], exp_s);
        end
        n_checks++;
        if (out_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_err: got %b expected 0", out_err[0]);
        end
        drain(0);
    endtask

    task automatic test_kat();
        logic [319:0] s;
        logic [319:0] exp_s;
        int lat;
        int rl [2];
        rl = '{6, 8};
        s = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
             64'h1011121314151617, 64'h18191a1b1c1d1e1f};
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 2; k++) begin
                exp_s = model_perm(s, rl[k]);
                start_job(u, s, rl[k]);
                wait_valid(u, lat);
                n_checks++;
                if (lat !== rl[k] / (u + 1)) begin
                    n_fail++;
                    $display("FAIL kat_latency[u%0d r%0d]: got %0d expected %0d", u + 1, rl[k], lat, rl[k] / (u + 1));
                end
                n_checks++;
                if ({out_err[u], out_state[u]} !== {1'b0, exp_s}) begin
                    n_fail++;
                    $display("FAIL kat_state[u%0d r%0d]: got err=%b %h expected err=0 %h", u + 1, rl[k], out_err[u], out_state[u], exp_s);
                end
                drain(u);
            end
        end
    endtask

    task automatic test_illegal();
        int cu [6];
        int cr [6];
        int lat;
        logic [319:0] s;
        cu = '{0, 0, 1, 1, 1, 0};
        cr = '{0, 13, 0, 13, 7, 15};
        for (int k = 0; k < 6; k++) begin
            s = rand320();
            start_job(cu[k], s, cr[k]);
            wait_valid(cu[k], lat);
            n_checks++;
            if (lat !== 1) begin
                n_fail++;
                $display("FAIL illegal_latency[u%0d r%0d]: got %0d expected 1", cu[k] + 1, cr[k], lat);
            end
            n_checks++;
            if ({out_err[cu[k]], out_state[cu[k]]} !== {1'b1, s}) begin
                n_fail++;
                $display("FAIL illegal_result[u%0d r%0d]: got err=%b %h expected err=1 %h", cu[k] + 1, cr[k], out_err[cu[k]], out_state[cu[k]], s);
            end
            drain(cu[k]);
        end
    endtask

    task automatic test_backpressure();
        logic [319:0] s;
        logic [319:0] exp_s;
        int lat;
        s = rand320();
        exp_s = model_perm(s, 10);
        start_job(1, s, 10);
        wait_valid(1, lat);
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 5", lat);
        end
        for (int c = 0; c < 20; c++) begin
            // Input activity while DONE must be ignored.
            in_state    = rand320();
            in_rounds   = 4'($urandom_range(1, 12));
            in_valid[1] = 1'b1;
            tick();
            n_checks++;
            if ({out_valid[1], in_ready[1], out_err[1], out_state[1]} !== {3'b100, exp_s}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got vld/rdy/err=%b%b%b %h expected 100 %h", c, out_valid[1], in_ready[1], out_err[1], out_state[1], exp_s);
            end
        end
        in_valid[1] = 1'b0;
        drain(1);
        n_checks++;
        if ({in_ready[1], out_valid[1]} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: got rdy/vld=%b%b expected 10", in_ready[1], out_valid[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [319:0] s;
        logic [319:0] exp_s;
        int lat;
        int seen;
        s = rand320();
        start_job(0, s, 12);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready[0], out_valid[0], out_err[0], out_state[0]} !== {3'b100, 320'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset: got rdy/vld/err=%b%b%b %h expected 100 0", in_ready[0], out_valid[0], out_err[0], out_state[0]);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid[0] !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_valid: got %0d valid cycles expected 0", seen);
        end
        s = rand320();
        exp_s = model_perm(s, 8);
        start_job(0, s, 8);
        wait_valid(0, lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL midrun_next_latency: got %0d expected 8", lat);
        end
        n_checks++;
        if ({out_err[0], out_state[0]} !== {1'b0, exp_s}) begin
            n_fail++;
            $display("FAIL midrun_next_state: got err=%b %h expected err=0 %h", out_err[0], out_state[0], exp_s);
        end
        drain(0);
    endtask

    task automatic test_back_to_back(input int u);
        logic [319:0] exp_q [$];
        logic [319:0] exp_s;
        logic [319:0] ps;
        int pr;
        int sent;
        int got;
        int pguard;
        int cguard;
        logic acc;
        logic take;
        sent = 0;
        got  = 0;
        fork
            begin
                pguard = 0;
                while (sent < 100 && pguard < 30000) begin
                    if (in_valid[u] !== 1'b1) begin
                        ps = rand320();
                        pr = (u == 0) ? int'($urandom_range(1, 12)) : 2 * int'($urandom_range(1, 6));
                        in_state    = ps;
                        in_rounds   = 4'(pr);
                        in_valid[u] = 1'b1;
                    end
                    acc = (in_ready[u] === 1'b1);
                    if (acc) begin
                        exp_q.push_back(model_perm(ps, pr));
                        sent++;
                    end
                    tick();
                    pguard++;
                    if (acc) in_valid[u] = 1'b0;
                end
                in_valid[u] = 1'b0;
            end
            begin
                cguard = 0;
                while (got < 100 && cguard < 30000) begin
                    out_ready[u] = 1'($urandom_range(0, 1));
                    take = (out_valid[u] === 1'b1) && out_ready[u];
                    if (take) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b_extra[u%0d]: got unexpected result %h expected none", u + 1, out_state[u]);
                        end else begin
                            exp_s = exp_q.pop_front();
                            if ({out_err[u], out_state[u]} !== {1'b0, exp_s}) begin
                                n_fail++;
                                $display("FAIL b2b_data[u%0d #%0d]: got err=%b %h expected err=0 %h", u + 1, got, out_err[u], out_state[u], exp_s);
                            end
                        end
                        got++;
                    end
                    tick();
                    cguard++;
                end
                out_ready[u] = 1'b0;
            end
        join
        n_checks++;
        if (sent !== 100 || got !== 100 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count[u%0d]: got sent=%0d received=%0d pending=%0d expected 100/100/0", u + 1, sent, got, exp_q.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_r12();
        test_kat();
        test_illegal();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
